// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: NREQ requesters share one register-file write port.
// Optional macro WBARB_LSU_PRIO_EN gives the top requester (LSU) absolute priority.
module wb_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [5*NREQ-1:0]      req_rd,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wb_stall,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [31:0]            rf_wsel
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef WBARB_LSU_PRIO_EN
  localparam bit LSU_PRIO = 1'b1;
`else
  localparam bit LSU_PRIO = 1'b0;
`endif

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic              xfer;
  logic              lsu_gnt;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;

  // Grants are suppressed in reset and while stalled, so a reset-cycle transfer never happens.
  always_comb begin : arbitrate
    logic [PTR_W-1:0] idx;
    grant   = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    lsu_gnt = 1'b0;
    idx     = '0;
    if (rst_n && !wb_stall) begin
      if (LSU_PRIO && req_valid[NREQ-1]) begin
        grant[NREQ-1] = 1'b1;
        gnt_idx       = PTR_W'(NREQ - 1);
        xfer          = 1'b1;
        lsu_gnt       = 1'b1;
      end
      for (int k = 0; k < NREQ; k++) begin
        idx = PTR_W'((int'(ptr_q) + k) % NREQ);
        if (!xfer && req_valid[idx] && !(LSU_PRIO && int'(idx) == NREQ - 1)) begin
          grant[idx] = 1'b1;
          gnt_idx    = idx;
          xfer       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && !lsu_gnt) begin
      ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // A transfer to r0 is accepted but never written; address/data then hold.
  always_comb begin
    rf_we_d    = xfer && (sel_rd != 5'd0);
    rf_waddr_d = rf_we_d ? sel_rd   : rf_waddr_q;
    rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    rf_wsel           = '0;
    rf_wsel[rf_waddr_q] = rf_we_q;
  end

  assign req_ready = grant;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus random traffic
// checked against a round-robin reference model (honours WBARB_LSU_PRIO_EN).
module tb_wb_port_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
`ifdef WBARB_LSU_PRIO_EN
  localparam bit LSU = 1'b1;
`else
  localparam bit LSU = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_rd;
  logic [DW*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wb_stall;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic [31:0]          rf_wsel;

  wb_port_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_wsel   (rf_wsel)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [NREQ-1:0] rdy; } rdy_exp_t;
  typedef struct { int cyc; logic we; logic [4:0] addr; logic [DW-1:0] data; } rf_exp_t;

  rdy_exp_t rdy_q[$];
  rf_exp_t  rf_q[$];

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: arbitration pointer and last written address/data.
  int             m_ptr  = 0;
  logic [4:0]     m_addr = '0;
  logic [DW-1:0]  m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic int modelGrant(input logic [NREQ-1:0] v);
    if (LSU && v[NREQ-1]) return NREQ - 1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (!(LSU && i == NREQ - 1) && v[i]) return i;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, predict ready now and the rf outputs next cycle.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [5*NREQ-1:0] rd,
                               input logic [DW*NREQ-1:0] d, input logic st, input logic rn);
    int g;
    rdy_exp_t re;
    rf_exp_t  fe;
    logic [5*NREQ-1:0]  rd_sh;
    logic [DW*NREQ-1:0] d_sh;
    req_valid = v;
    req_rd    = rd;
    req_data  = d;
    wb_stall  = st;
    rst_n     = rn;
    g = (rn && !st) ? modelGrant(v) : -1;
    re.cyc = cyc;
    re.rdy = '0;
    if (g >= 0) re.rdy[g] = 1'b1;
    rdy_q.push_back(re);
    fe.cyc = cyc + 1;
    fe.we  = 1'b0;
    if (!rn) begin
      m_ptr  = 0;
      m_addr = '0;
      m_data = '0;
    end else if (g >= 0) begin
      rd_sh = rd >> (5 * g);
      d_sh  = d >> (DW * g);
      if (!(LSU && g == NREQ - 1)) m_ptr = (g + 1) % NREQ;
      if (rd_sh[4:0] != 5'd0) begin
        fe.we  = 1'b1;
        m_addr = rd_sh[4:0];
        m_data = d_sh[DW-1:0];
      end
    end
    fe.addr = m_addr;
    fe.data = m_data;
    rf_q.push_back(fe);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents this cycle against the scoreboard.
  always @(negedge clk) begin
    if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
      rdy_exp_t re;
      re = rdy_q.pop_front();
      checkOutput("req_ready", 64'(req_ready), 64'(re.rdy));
    end
    if (rf_q.size() > 0 && rf_q[0].cyc == cyc) begin
      rf_exp_t fe;
      logic [31:0] wsel_exp;
      fe = rf_q.pop_front();
      wsel_exp = fe.we ? (32'd1 << fe.addr) : 32'd0;
      checkOutput("rf_we",    64'(rf_we),    64'(fe.we));
      checkOutput("rf_waddr", 64'(rf_waddr), 64'(fe.addr));
      checkOutput("rf_wdata", 64'(rf_wdata), 64'(fe.data));
      checkOutput("rf_wsel",  64'(rf_wsel),  64'(wsel_exp));
    end
  end

  function automatic logic [5*NREQ-1:0] packRd(input int r0, input int r1, input int r2, input int r3);
    return {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
  endfunction

  initial begin
    logic [5*NREQ-1:0]  rd_all;
    logic [DW*NREQ-1:0] d_all;
    rst_n     = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    wb_stall  = 1'b0;
    @(posedge clk);
    #1;
    rd_all = packRd(1, 2, 3, 4);
    d_all  = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

    // Reset with all requesters valid: no grants, outputs cleared.
    repeat (2) applyStimulus(4'b1111, rd_all, d_all, 1'b0, 1'b0);
    // All valid for four cycles.
    repeat (4) applyStimulus(4'b1111, rd_all, d_all, 1'b0, 1'b1);
    // Requester 2 writes r0: accepted but not written.
    applyStimulus(4'b0100, packRd(7, 8, 0, 9), {32'h1, 32'hDEADBEEF, 32'h2, 32'h3}, 1'b0, 1'b1);
    applyStimulus(4'b1111, rd_all, d_all, 1'b0, 1'b1);
    // Stall with requesters 1 and 3 pending.
    repeat (3) applyStimulus(4'b1010, rd_all, d_all, 1'b1, 1'b1);
    applyStimulus(4'b1010, rd_all, d_all, 1'b0, 1'b1);
    applyStimulus(4'b0000, rd_all, d_all, 1'b0, 1'b1);
    // Single write to r5.
    applyStimulus(4'b0001, packRd(5, 6, 7, 8), {32'h4, 32'h3, 32'h2, 32'h12345678}, 1'b0, 1'b1);
    // Requesters 0 and 3 contending.
    repeat (4) applyStimulus(4'b1001, rd_all, d_all, 1'b0, 1'b1);
    // Reset coinciding with a grant, then first grant after release.
    applyStimulus(4'b0100, rd_all, d_all, 1'b0, 1'b1);
    applyStimulus(4'b1111, rd_all, d_all, 1'b0, 1'b0);
    applyStimulus(4'b0110, rd_all, d_all, 1'b0, 1'b1);

    // Random traffic with occasional stalls and resets.
    for (int n = 0; n < 300; n++) begin
      rd_all = 20'($urandom);
      d_all  = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(4'($urandom), rd_all, d_all,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
    end

    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(rdy_q.size() + rf_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
